// File: rtl/uart1_tx_if.sv
// uart1_tx_if: read port of the UART1 transmit FIFO (non-show-ahead)
interface uart1_tx_if;
  logic       tx_fifo_rden;
  logic [7:0] tx_fifo_rdata;
  logic       tx_fifo_empty;
  modport master (output tx_fifo_rden, input tx_fifo_rdata, input tx_fifo_empty);
  modport slave  (input tx_fifo_rden, output tx_fifo_rdata, output tx_fifo_empty);
endinterface

// File: rtl/uart1_tx.sv
// uart1_tx: UART1 8N1 serializer with stop-bit prefetch; define UART1_PARITY_EN for 8E1 frames
module uart1_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  uart1_tx_if.master fifo,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);
  localparam logic [15:0] LP_LAST      = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LP_LAST_STOP = 3'(STOP_BITS - 1);
`ifdef UART1_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif
  state_t      r_state, w_next;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift, r_hold;
  logic        r_pf_valid, r_pf_pend;
  logic        w_bit_end, w_last_stop, w_frame_end, w_pf_rd, w_restart;
  assign w_bit_end   = r_baud == LP_LAST;
  assign w_last_stop = r_bit == LP_LAST_STOP;
  assign w_frame_end = r_state == S_STOP && w_last_stop && w_bit_end;
  assign w_pf_rd     = r_state == S_STOP && w_last_stop && r_baud == 16'd0 && ena && !fifo.tx_fifo_empty && !r_pf_valid;
  assign w_restart   = w_frame_end && (r_pf_valid || r_pf_pend);
  assign busy        = r_state != S_IDLE;
  // next state plus line, read-strobe and done outputs decoded from the current state
  always_comb begin
    w_next            = r_state;
    fifo.tx_fifo_rden = w_pf_rd;
    txd               = 1'b1;
    tx_done           = 1'b0;
    case (r_state)
      S_IDLE:   w_next = (ena && !fifo.tx_fifo_empty) ? S_FETCH : S_IDLE;
      S_FETCH:  begin
        fifo.tx_fifo_rden = 1'b1;
        w_next            = S_LOAD;
      end
      S_LOAD:   w_next = S_START;
      S_START:  begin
        txd    = 1'b0;
        w_next = w_bit_end ? S_DATA : S_START;
      end
`ifdef UART1_PARITY_EN
      S_DATA:   begin
        txd    = r_shift[r_bit];
        w_next = (w_bit_end && r_bit == 3'd7) ? S_PARITY : S_DATA;
      end
      S_PARITY: begin
        txd    = ^r_shift;
        w_next = w_bit_end ? S_STOP : S_PARITY;
      end
`else
      S_DATA:   begin
        txd    = r_shift[r_bit];
        w_next = (w_bit_end && r_bit == 3'd7) ? S_STOP : S_DATA;
      end
`endif
      S_STOP:   begin
        tx_done = w_frame_end;
        w_next  = !w_frame_end ? S_STOP : w_restart ? S_START : S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end
  // state register, bit timing and byte capture; a prefetched byte may still be in flight on rdata at frame end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud     <= 16'd0;
      r_bit      <= 3'd0;
      r_shift    <= 8'd0;
      r_hold     <= 8'd0;
      r_pf_valid <= 1'b0;
      r_pf_pend  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_baud     <= (r_state inside {S_IDLE, S_FETCH, S_LOAD} || w_bit_end) ? 16'd0 : r_baud + 16'd1;
      r_bit      <= !w_bit_end ? r_bit : (r_state == S_DATA || (r_state == S_STOP && !w_last_stop)) ? r_bit + 3'd1 : 3'd0;
      r_pf_pend  <= w_pf_rd;
      r_hold     <= r_pf_pend ? fifo.tx_fifo_rdata : r_hold;
      r_pf_valid <= (r_pf_valid || r_pf_pend) && !w_restart;
      r_shift    <= r_state == S_LOAD ? fifo.tx_fifo_rdata : w_restart ? (r_pf_pend ? fifo.tx_fifo_rdata : r_hold) : r_shift;
    end
  end
endmodule

// File: tb/tb_uart1_tx.sv
// tb_uart1_tx: scoreboard bench for uart1_tx with a FIFO model and a txd frame decoder
module tb_uart1_tx;
  localparam int CPB = 4;
`ifdef UART1_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAST = NB * CPB - 1;

  logic clk = 1'b0, rst = 1'b0, ena = 1'b0;
  logic txd, busy, tx_done;
  uart1_tx_if bus();
  uart1_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .fifo(bus), .txd(txd), .busy(busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:63];
  int wr_ptr = 0, rd_ptr = 0, rden_cnt = 0, under = 0;
  assign bus.tx_fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk)
    if (bus.tx_fifo_rden === 1'b1) begin
      rden_cnt <= rden_cnt + 1;
      if (wr_ptr == rd_ptr) under <= under + 1;
      else begin
        bus.tx_fifo_rdata <= mem[rd_ptr % 64];
        rd_ptr <= rd_ptr + 1;
      end
    end

  int m_cnt = 0, m_gap = 0, m_gap_rec = 0, m_start = 0, rx_cnt = 0;
  bit m_act = 0, m_stab = 0, m_done = 0;
  logic [10:0] m_bits = '0;
  logic [10:0] rx_bits [0:63];
  bit rx_stab [0:63], rx_done [0:63];
  int rx_gap [0:63], rx_start [0:63];
  always @(negedge clk) begin
    if (!rst) begin
      m_act <= 1'b0;
      m_gap <= 0;
    end else if (!m_act) begin
      if (txd === 1'b0) begin
        m_act <= 1'b1; m_cnt <= 1; m_bits <= '0; m_stab <= 1'b1;
        m_done <= (tx_done === 1'b0); m_gap_rec <= m_gap; m_start <= cyc;
      end else m_gap <= m_gap + 1;
    end else begin
      if (m_cnt % CPB == 0) m_bits[m_cnt / CPB] <= txd;
      else if (txd !== m_bits[m_cnt / CPB]) m_stab <= 1'b0;
      if (tx_done !== (m_cnt == LAST)) m_done <= 1'b0;
      if (m_cnt == LAST) begin
        rx_bits[rx_cnt % 64]  <= m_bits;
        rx_stab[rx_cnt % 64]  <= m_stab && (txd === m_bits[NB-1]);
        rx_done[rx_cnt % 64]  <= m_done && (tx_done === 1'b1);
        rx_gap[rx_cnt % 64]   <= m_gap_rec;
        rx_start[rx_cnt % 64] <= m_start;
        rx_cnt <= rx_cnt + 1;
        m_act  <= 1'b0;
        m_gap  <= 0;
      end else m_cnt <= m_cnt + 1;
    end
  end

  int n_chk = 0, n_pass = 0;
  logic [7:0] exp_q [$];
  logic [7:0] e;

  task automatic push(input logic [7:0] b, input bit expect_it);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
    if (expect_it) exp_q.push_back(b);
  endtask

  task automatic wait_rx(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = rx_cnt >= target;
    end
    @(negedge clk);
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = txd === 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; ena = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (txd !== 1'b1) $display("FAIL reset_txd got %b want 1", txd); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (bus.tx_fifo_rden !== 1'b0) $display("FAIL reset_rden got %b want 0", bus.tx_fifo_rden); else n_pass++;
    n_chk++; if (tx_done !== 1'b0) $display("FAIL reset_done got %b want 0", tx_done); else n_pass++;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_empty_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single;
    int base, r0;
    bit ok;
    base = rx_cnt; r0 = rden_cnt;
    push(8'h7F, 1'b1);
    wait_rx(base + 1, 200, ok);
    n_chk++; if (!ok) $display("FAIL single_timeout got %0d frames want 1", rx_cnt - base); else n_pass++;
    for (int i = base; i < rx_cnt; i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_chk++;
      if ({rx_bits[i%64][8:1], rx_bits[i%64][NB-1], rx_stab[i%64], rx_done[i%64]} !== {e, 3'b111})
        $display("FAIL single_frame got data=%h stop=%b stable=%b done=%b want data=%h stop=1 stable=1 done=1",
                 rx_bits[i%64][8:1], rx_bits[i%64][NB-1], rx_stab[i%64], rx_done[i%64], e);
      else n_pass++;
    end
    n_chk++; if (rden_cnt - r0 !== 1) $display("FAIL single_rden got %0d want 1", rden_cnt - r0); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_after got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int base, r0, gaps;
    bit ok;
    logic [7:0] rec [8] = '{8'hFF, 8'h7F, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h0C, 8'h00};
    base = rx_cnt; r0 = rden_cnt; gaps = 0;
    foreach (rec[k]) push(rec[k], 1'b1);
    wait_rx(base + 8, 800, ok);
    n_chk++; if (!ok) $display("FAIL b2b_timeout got %0d frames want 8", rx_cnt - base); else n_pass++;
    for (int i = base; i < rx_cnt; i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      if (i > base && rx_gap[i%64] != 0) gaps++;
      n_chk++;
      if ({rx_bits[i%64][8:1], rx_bits[i%64][NB-1], rx_stab[i%64], rx_done[i%64]} !== {e, 3'b111})
        $display("FAIL b2b_frame%0d got data=%h stop=%b stable=%b done=%b want data=%h stop=1 stable=1 done=1",
                 i - base, rx_bits[i%64][8:1], rx_bits[i%64][NB-1], rx_stab[i%64], rx_done[i%64], e);
      else n_pass++;
    end
    n_chk++; if (gaps !== 0) $display("FAIL b2b_gaps got %0d gapped frames want 0", gaps); else n_pass++;
    n_chk++;
    if (rx_start[(base+7)%64] - rx_start[base%64] !== 7 * NB * CPB)
      $display("FAIL b2b_span got %0d want %0d", rx_start[(base+7)%64] - rx_start[base%64], 7 * NB * CPB);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_chk++; if (rden_cnt - r0 !== 8) $display("FAIL b2b_rden got %0d want 8", rden_cnt - r0); else n_pass++;
    n_chk++; if (under !== 0) $display("FAIL b2b_underflow got %0d want 0", under); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL b2b_busy_after got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_ena_drop;
    int base, r0, lows, rds;
    bit ok;
    base = rx_cnt; r0 = rden_cnt; lows = 0; rds = 0;
    push(8'hA5, 1'b1); push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    wait_start(50, ok);
    n_chk++; if (!ok) $display("FAIL drop_start got no start want start"); else n_pass++;
    repeat (12) @(negedge clk);
    ena = 1'b0;
    wait_rx(base + 1, 200, ok);
    for (int i = base; i < rx_cnt; i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_chk++;
      if ({rx_bits[i%64][8:1], rx_bits[i%64][NB-1], rx_stab[i%64], rx_done[i%64]} !== {e, 3'b111})
        $display("FAIL drop_frame got data=%h stop=%b stable=%b done=%b want data=%h stop=1 stable=1 done=1",
                 rx_bits[i%64][8:1], rx_bits[i%64][NB-1], rx_stab[i%64], rx_done[i%64], e);
      else n_pass++;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
      if (bus.tx_fifo_rden !== 1'b0) rds++;
    end
    n_chk++; if (lows !== 0) $display("FAIL gate_txd got %0d low cycles want 0", lows); else n_pass++;
    n_chk++; if (rds !== 0) $display("FAIL gate_rden got %0d strobes want 0", rds); else n_pass++;
    n_chk++; if (rden_cnt - r0 !== 1) $display("FAIL drop_rden got %0d want 1", rden_cnt - r0); else n_pass++;
  endtask

  task automatic test_ena_gate;
    int base, r0, lat;
    bit ok, rd1;
    base = rx_cnt; r0 = rden_cnt; lat = 0; rd1 = 1'b0; ok = 1'b0;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    ena = 1'b1;
    for (int i = 1; i <= 10 && !ok; i++) begin
      @(negedge clk);
      if (i == 1) rd1 = bus.tx_fifo_rden;
      if (txd === 1'b0) begin ok = 1'b1; lat = i; end
    end
    n_chk++; if (lat !== 3) $display("FAIL gate_latency got %0d want 3", lat); else n_pass++;
    n_chk++; if (rd1 !== 1'b1) $display("FAIL gate_fetch_rden got %b want 1", rd1); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = bus.tx_fifo_rden === 1'b1;
    end
    n_chk++; if (!ok) $display("FAIL gate_prefetch got no strobe want strobe"); else n_pass++;
    @(posedge clk); #1 ena = 1'b0;
    wait_rx(base + 2, 200, ok);
    repeat (30) @(negedge clk);
    n_chk++; if (rx_cnt - base !== 2) $display("FAIL late_drop_frames got %0d want 2", rx_cnt - base); else n_pass++;
    n_chk++; if (rden_cnt - r0 !== 2) $display("FAIL late_drop_rden got %0d want 2", rden_cnt - r0); else n_pass++;
    exp_q.push_back(8'h33);
    ena = 1'b1;
    wait_rx(base + 3, 200, ok);
    for (int i = base; i < rx_cnt; i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_chk++;
      if ({rx_bits[i%64][8:1], rx_bits[i%64][NB-1], rx_stab[i%64], rx_done[i%64]} !== {e, 3'b111})
        $display("FAIL gate_frame%0d got data=%h stop=%b stable=%b done=%b want data=%h stop=1 stable=1 done=1",
                 i - base, rx_bits[i%64][8:1], rx_bits[i%64][NB-1], rx_stab[i%64], rx_done[i%64], e);
      else n_pass++;
    end
    n_chk++; if (rden_cnt - r0 !== 3) $display("FAIL gate_rden_total got %0d want 3", rden_cnt - r0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int base, r0, busys;
    bit ok;
    busys = 0;
    push(8'h5A, 1'b0);
    wait_start(50, ok);
    n_chk++; if (!ok) $display("FAIL rmid_start got no start want start"); else n_pass++;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (txd !== 1'b1) $display("FAIL rmid_txd got %b want 1", txd); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (bus.tx_fifo_rden !== 1'b0) $display("FAIL rmid_rden got %b want 0", bus.tx_fifo_rden); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    base = rx_cnt; r0 = rden_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busys++;
    end
    n_chk++; if (busys !== 0) $display("FAIL rmid_idle_busy got %0d busy cycles want 0", busys); else n_pass++;
    n_chk++; if (rden_cnt - r0 !== 0) $display("FAIL rmid_idle_rden got %0d want 0", rden_cnt - r0); else n_pass++;
    n_chk++; if (rx_cnt - base !== 0) $display("FAIL rmid_frames got %0d want 0", rx_cnt - base); else n_pass++;
  endtask

`ifdef UART1_PARITY_EN
  task automatic test_parity;
    int base;
    bit ok;
    base = rx_cnt;
    push(8'h03, 1'b1); push(8'h07, 1'b1);
    wait_rx(base + 2, 300, ok);
    n_chk++; if (!ok) $display("FAIL parity_timeout got %0d frames want 2", rx_cnt - base); else n_pass++;
    for (int i = base; i < rx_cnt; i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      n_chk++;
      if ({rx_bits[i%64][8:1], rx_bits[i%64][9], rx_bits[i%64][10], rx_stab[i%64], rx_done[i%64]} !== {e, ^e, 3'b111})
        $display("FAIL parity_frame got data=%h par=%b stop=%b stable=%b done=%b want data=%h par=%b stop=1 stable=1 done=1",
                 rx_bits[i%64][8:1], rx_bits[i%64][9], rx_bits[i%64][10], rx_stab[i%64], rx_done[i%64], e, ^e);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_ena_drop;
    test_ena_gate;
`ifdef UART1_PARITY_EN
    test_parity;
`endif
    test_reset_mid;
    n_chk++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
